// File: rtl/sram_axi_resp.sv
// Responder end of one SRAM-like core port (req/addr_ok/data_ok), issuing each
// accepted request as a single-beat AXI3 read or write with one transaction in flight.
module sram_axi_resp #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata_i,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_fin;
  logic                w_fin;
  logic                accept;
  logic                completing;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a completion with a new accept chains straight into the next transaction
  always_comb begin
    state_nxt = state;
    aw_fin    = aw_done || (awvalid && awready);
    w_fin     = w_done || (wvalid && wready);
    case (state)
      IDLE:       if (accept) state_nxt = wr ? WR_AW : RD_A;
      RD_A:       if (arready) state_nxt = RD_D;
      WR_AW:      if (aw_fin && w_fin) state_nxt = WR_B;
      RD_D, WR_B: if (completing) state_nxt = accept ? (wr ? WR_AW : RD_A) : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state and per-channel done flags
  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    completing = 1'b0;
    case (state)
      RD_A:  arvalid = 1'b1;
      RD_D: begin
        rready     = 1'b1;
        completing = rvalid;
      end
      WR_AW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      WR_B: begin
        bready     = 1'b1;
        completing = bvalid;
      end
      default: ;
    endcase
    accept  = req && ((state == IDLE) || completing);
    addr_ok = accept;
    data_ok = completing;
  end

  // Request latch and AW/W completion tracking
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      aw_done <= (state_nxt == WR_AW) && aw_fin;
      w_done  <= (state_nxt == WR_AW) && w_fin;
    end
  end

  // Byte strobes from latched size and low address bits; size 3 writes nothing
  always_comb begin
    wstrb = '0;
    case (size_q)
      2'd0:    wstrb = STRB_W'(4'b0001 << addr_q[1:0]);
      2'd1:    wstrb = STRB_W'(4'b0011 << addr_q[1:0]);
      2'd2:    wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata_o = wr_q ? wdata_q : wdata_q;
  assign wlast   = 1'b1;
  assign rdata   = rdata_i;

endmodule

// File: tb/tb_sram_axi_resp.sv
// Randomized scoreboard bench for sram_axi_resp: an AXI slave memory model answers the DUT,
// a transaction-level reference memory predicts load data, strobes and latencies.
`timescale 1ns/1ps
module tb_sram_axi_resp;

  localparam logic [3:0] ID = 4'd1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata_o;
  logic [2:0]  arsize, awsize;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;

  sram_axi_resp #(.AXI_ID(ID)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata_i(rdata_i), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_o(wdata_o), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          acc_cyc;
    bit          fast;
  } txn_t;

  txn_t        core_q[$];
  txn_t        axi_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] ref_saved[int];
  logic [31:0] slv_mem[int];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued = 0;
  int accepted = 0;
  int issue_limit = 0;
  int dok_cnt = 0;
  int force_kind = 0;
  bit drv_en = 0;
  bit fast = 0;
  bit hold_w = 0;

  // slave-side state
  bit          acc_last = 0;
  bit          r_pend = 0;
  bit          b_pend = 0;
  bit          aw_seen = 0;
  bit          w_seen = 0;
  logic [31:0] r_word = '0;
  logic [31:0] aw_addr_s = '0;
  logic [2:0]  aw_size_s = '0;
  logic [3:0]  aw_id_s = '0;
  logic [31:0] w_data_s = '0;
  logic [3:0]  w_strb_s = '0;
  logic [3:0]  w_id_s = '0;
  logic        w_last_s = 1'b0;

  // monitor-side state
  bit          prev_arv = 0, prev_arr = 0, prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wrdy = 0;
  logic [31:0] prev_araddr = '0, prev_awaddr = '0, prev_wdata = '0;
  int          last_dok_cyc = 0;
  bit          last_fast = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int k);
    return 32'h5A00_0000 ^ (32'(k) * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] ref_read(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] slv_read(input int k);
    return slv_mem.exists(k) ? slv_mem[k] : init_word(k);
  endfunction

  // Bytes touched: 2^size bytes from the low address bits, whole word for size 2, none for size 3
  function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] s;
    int n;
    s = 4'h0;
    if (sz == 2'd2) return 4'hF;
    if (sz == 2'd3) return 4'h0;
    n = 1 << sz;
    for (int b = 0; b < 4; b++)
      if (b >= int'(lo) && b < int'(lo) + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Core driver + AXI slave model; inputs change on negedge, handshakes resolved at +2
  always @(negedge aclk) begin
    if (!aresetn) begin
      req = 1'b0;
      acc_last = 0;
      r_pend = 0;
      b_pend = 0;
      aw_seen = 0;
      w_seen = 0;
      rvalid = 1'b0;
      bvalid = 1'b0;
      core_q.delete();
      axi_q.delete();
      ref_mem = ref_saved;
    end else if (drv_en) begin
      txn_t t;
      int k;
      if (acc_last) begin
        req = 1'b0;
        acc_last = 0;
      end
      arready = fast || ($urandom_range(0, 3) != 0);
      awready = !hold_w && (fast || ($urandom_range(0, 3) != 0));
      wready  = !hold_w && (fast || ($urandom_range(0, 3) != 0));
      rvalid  = r_pend && (fast || ($urandom_range(0, 2) != 0));
      rdata_i = rvalid ? r_word : $urandom();
      bvalid  = b_pend && (fast || ($urandom_range(0, 2) != 0));
      if (!req) begin
        addr  = $urandom();
        wdata = $urandom();
        wr    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        if (issued < issue_limit && (fast || $urandom_range(0, 2) != 0)) begin
          req   = 1'b1;
          wr    = (force_kind == 1) ? 1'b0 : (force_kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
          size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          addr  = 32'h1FC0_0000 + 32'($urandom_range(0, 63));
          wdata = $urandom();
          issued++;
        end
      end
      #2;
      if (req && addr_ok) begin
        t.wr = wr;
        t.size = size;
        t.addr = addr;
        t.wdata = wdata;
        t.acc_cyc = cyc;
        t.fast = fast;
        t.exp_rdata = '0;
        k = int'(addr[31:2]);
        if (!wr) t.exp_rdata = ref_read(k);
        else ref_mem[k] = merge(ref_read(k), wdata, ref_strb(size, addr[1:0]));
        core_q.push_back(t);
        axi_q.push_back(t);
        accepted++;
        acc_last = 1;
      end
      if (arvalid && arready) begin
        chk("ar_expected", 64'(axi_q.size() != 0), 64'd1);
        if (axi_q.size() != 0) begin
          t = axi_q.pop_front();
          chk("ar_is_load", 64'(t.wr), 64'd0);
          chk("araddr", 64'(araddr), 64'(t.addr));
          chk("arsize", 64'(arsize), 64'({1'b0, t.size}));
          chk("arid", 64'(arid), 64'(ID));
        end
        r_pend = 1;
        r_word = slv_read(int'(araddr[31:2]));
      end
      if (rvalid && rready) r_pend = 0;
      if (awvalid && awready) begin
        chk("aw_once", 64'(aw_seen), 64'd0);
        aw_seen = 1;
        aw_addr_s = awaddr;
        aw_size_s = awsize;
        aw_id_s = awid;
      end
      if (wvalid && wready) begin
        chk("w_once", 64'(w_seen), 64'd0);
        w_seen = 1;
        w_data_s = wdata_o;
        w_strb_s = wstrb;
        w_id_s = wid;
        w_last_s = wlast;
      end
      if (aw_seen && w_seen) begin
        chk("wr_expected", 64'(axi_q.size() != 0), 64'd1);
        if (axi_q.size() != 0) begin
          t = axi_q.pop_front();
          chk("wr_is_store", 64'(t.wr), 64'd1);
          chk("awaddr", 64'(aw_addr_s), 64'(t.addr));
          chk("awsize", 64'(aw_size_s), 64'({1'b0, t.size}));
          chk("aw_w_id", 64'({aw_id_s, w_id_s}), 64'({ID, ID}));
          chk("wdata", 64'(w_data_s), 64'(t.wdata));
          chk("wstrb", 64'(w_strb_s), 64'(ref_strb(t.size, t.addr[1:0])));
          chk("wlast", 64'(w_last_s), 64'd1);
        end
        slv_mem[int'(aw_addr_s[31:2])] = merge(slv_read(int'(aw_addr_s[31:2])), w_data_s, w_strb_s);
        b_pend = 1;
        aw_seen = 0;
        w_seen = 0;
      end
      if (bvalid && bready) b_pend = 0;
    end
  end

  // Monitor: pops the scoreboard on data_ok and watches AXI valid/payload stability
  always @(negedge aclk) begin
    #1;
    if (!aresetn) begin
      prev_arv = 0;
      prev_awv = 0;
      prev_wv = 0;
      last_fast = 0;
    end else if (drv_en) begin
      txn_t t;
      if (data_ok) begin
        chk("dok_expected", 64'(core_q.size() != 0), 64'd1);
        if (core_q.size() != 0) begin
          t = core_q.pop_front();
          dok_cnt++;
          if (!t.wr) chk("rdata", 64'(rdata), 64'(t.exp_rdata));
          if (t.fast) chk("latency", 64'(cyc - t.acc_cyc), 64'd2);
          if (t.fast && last_fast) chk("back_to_back", 64'(t.acc_cyc), 64'(last_dok_cyc));
          last_dok_cyc = cyc;
          last_fast = t.fast;
        end
      end
      if (req && addr_ok) chk("one_outstanding", 64'(core_q.size()), 64'd0);
      if (aw_seen != w_seen) chk("bready_early", 64'(bready), 64'd0);
      if (prev_arv && !prev_arr) begin
        chk("arvalid_hold", 64'(arvalid), 64'd1);
        chk("araddr_stable", 64'(araddr), 64'(prev_araddr));
      end
      if (prev_awv && !prev_awr) begin
        chk("awvalid_hold", 64'(awvalid), 64'd1);
        chk("awaddr_stable", 64'(awaddr), 64'(prev_awaddr));
      end
      if (prev_wv && !prev_wrdy) begin
        chk("wvalid_hold", 64'(wvalid), 64'd1);
        chk("wdata_stable", 64'(wdata_o), 64'(prev_wdata));
      end
      prev_arv = arvalid;
      prev_arr = arready;
      prev_araddr = araddr;
      prev_awv = awvalid;
      prev_awr = awready;
      prev_awaddr = awaddr;
      prev_wv = wvalid;
      prev_wrdy = wready;
      prev_wdata = wdata_o;
    end
  end

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (n < budget && !(accepted == issue_limit && core_q.size() == 0)) begin
      @(negedge aclk);
      n++;
    end
    chk(nm, 64'(accepted == issue_limit && core_q.size() == 0), 64'd1);
  endtask

  initial begin
    int n;
    int dok_before;
    #12;
    chk("rst_outputs", 64'({arvalid, awvalid, wvalid, rready, bready, data_ok, addr_ok}), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    chk("idle_after_rst", 64'({arvalid, awvalid, wvalid, rready, bready, data_ok}), 64'd0);

    // Immediate-ready slave: 2-cycle latency and back-to-back streaming
    fast = 1;
    drv_en = 1;
    issue_limit = 20;
    wait_drain(400, "drain_fast");

    // Randomized readies, valids and request gaps
    fast = 0;
    issue_limit += 300;
    wait_drain(8000, "drain_random");

    // Store stuck in WR_AW, then asynchronous reset
    ref_saved = ref_mem;
    hold_w = 1;
    force_kind = 2;
    issue_limit += 1;
    n = 0;
    while (n < 60 && !awvalid) begin
      @(negedge aclk);
      n++;
    end
    chk("reach_wr_aw", 64'({awvalid, wvalid}), 64'b11);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_async_valids", 64'({arvalid, awvalid, wvalid, rready, bready, data_ok}), 64'd0);
    repeat (3) @(negedge aclk);
    #1;
    aresetn = 1'b1;
    hold_w = 0;
    @(negedge aclk);
    #1;
    chk("idle_after_midrst", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);

    // Fresh loads after the abandoned store
    dok_before = dok_cnt;
    force_kind = 1;
    fast = 1;
    issue_limit += 5;
    wait_drain(200, "drain_post_rst");
    chk("fresh_loads_done", 64'(dok_cnt - dok_before), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
